// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift unit: op encodings, FIFO states, default widths.
package shift_pkg;

  localparam int DW_DEF    = 16;
  localparam int SW_DEF    = 4;
  localparam int TAGW_DEF  = 4;
  localparam int DEPTH_DEF = 2;
  localparam int SPLIT_DEF = 2;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

endpackage

// File: rtl/shift_ex_stage_if.sv
// Issue (ID/EX -> shift) and result (shift -> EX/MEM) handshake bundle.
interface shift_ex_stage_if #(
  parameter int DW   = shift_pkg::DW_DEF,
  parameter int SW   = shift_pkg::SW_DEF,
  parameter int TAGW = shift_pkg::TAGW_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_shamt;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_z;

  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_z
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_z
  );
endinterface

// File: rtl/shift_ex_stage_barrel_shift16.sv
// Four-op logarithmic barrel shifter; the layers below SPLIT and the remaining layers are
// exposed as separate halves so a pipeline register can sit between them.
module barrel_shift16
  import shift_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input  logic [1:0]        lo_op_i,
  input  logic [DW-1:0]     lo_data_i,
  input  logic [SPLIT-1:0]  lo_shamt_i,
  output logic [DW-1:0]     lo_data_o,
  input  logic [1:0]        hi_op_i,
  input  logic [DW-1:0]     hi_data_i,
  input  logic [SW-1:SPLIT] hi_shamt_i,
  output logic [DW-1:0]     hi_data_o
);

  // Partial SRA keeps the original MSB, so layers compose for every op.
  function automatic logic [DW-1:0] layer(input logic [1:0] op, input logic [DW-1:0] d,
                                          input int unsigned k);
    logic [DW-1:0] r;
    r = d;
    case (shift_op_e'(op))
      OP_SLL:  r = d << k;
      OP_SRL:  r = d >> k;
      OP_ROL:  r = (d << k) | (d >> (DW - k));
      OP_SRA:  r = $unsigned($signed(d) >>> k);
      default: r = d;
    endcase
    return r;
  endfunction

  logic [DW-1:0] lo_acc;
  logic [DW-1:0] hi_acc;

  always_comb begin
    lo_acc = lo_data_i;
    for (int unsigned i = 0; i < SPLIT; i++) begin
      if (lo_shamt_i[i]) lo_acc = layer(lo_op_i, lo_acc, 32'd1 << i);
    end
  end

  always_comb begin
    hi_acc = hi_data_i;
    for (int unsigned i = SPLIT; i < SW; i++) begin
      if (hi_shamt_i[i]) hi_acc = layer(hi_op_i, hi_acc, 32'd1 << i);
    end
  end

  assign lo_data_o = lo_acc;
  assign hi_data_o = hi_acc;

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage shift unit: barrel shift into a small result FIFO with flush.
// Build option SHIFT_PIPE2_EN registers the shifter between its low and high layers.
module shift_ex_stage
  import shift_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SW    = SW_DEF,
  parameter int TAGW  = TAGW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  shift_ex_stage_if.slave bus
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SPLIT = SPLIT_DEF;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [TAGW-1:0] tag;
    logic            z;
  } entry_t;

  logic              accept, push, pop, inflight;
  logic [DW-1:0]     lo_res, shift_res;
  logic [1:0]        st_op;
  logic [DW-1:0]     st_data;
  logic [SW-1:SPLIT] st_shamt;
  logic [TAGW-1:0]   st_tag;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_state_e       state_q, state_d;

  assign accept      = bus.in_valid && bus.in_ready;
  assign pop         = bus.out_valid && bus.out_ready && !flush;
  assign bus.in_ready = !flush && ((int'(count_q) + int'(inflight)) < DEPTH);

`ifdef SHIFT_PIPE2_EN
  logic              s1_valid_q;
  logic [1:0]        s1_op_q;
  logic [DW-1:0]     s1_data_q;
  logic [SW-1:SPLIT] s1_shamt_q;
  logic [TAGW-1:0]   s1_tag_q;

  // accept is already low during flush, so the stage-1 slot empties on flush too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_data_q  <= '0;
      s1_shamt_q <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q    <= bus.in_op;
        s1_data_q  <= lo_res;
        s1_shamt_q <= bus.in_shamt[SW-1:SPLIT];
        s1_tag_q   <= bus.in_tag;
      end
    end
  end

  assign inflight = s1_valid_q;
  assign push     = s1_valid_q && !flush;
  assign st_op    = s1_op_q;
  assign st_data  = s1_data_q;
  assign st_shamt = s1_shamt_q;
  assign st_tag   = s1_tag_q;
`else
  assign inflight = 1'b0;
  assign push     = accept;
  assign st_op    = bus.in_op;
  assign st_data  = lo_res;
  assign st_shamt = bus.in_shamt[SW-1:SPLIT];
  assign st_tag   = bus.in_tag;
`endif

  barrel_shift16 #(.DW(DW), .SW(SW), .SPLIT(SPLIT)) u_shift (
    .lo_op_i   (bus.in_op),
    .lo_data_i (bus.in_data),
    .lo_shamt_i(bus.in_shamt[SPLIT-1:0]),
    .lo_data_o (lo_res),
    .hi_op_i   (st_op),
    .hi_data_i (st_data),
    .hi_shamt_i(st_shamt),
    .hi_data_o (shift_res)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    if (count_d == '0)              state_d = ST_EMPTY;
    else if (count_d == CW'(DEPTH)) state_d = ST_FULL;
    else                            state_d = ST_PARTIAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{data: shift_res, tag: st_tag, z: (shift_res == '0)};
  end

  // Storage is unreset; outputs are gated so an empty FIFO always presents zeros.
  assign head = mem[rd_ptr_q];

  always_comb begin
    bus.out_valid = (state_q != ST_EMPTY);
    bus.out_data  = bus.out_valid ? head.data : '0;
    bus.out_tag   = bus.out_valid ? head.tag  : '0;
    bus.out_z     = bus.out_valid ? head.z    : 1'b0;
  end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage with a queue-based reference model checked every cycle.
module tb_shift_ex_stage;
  import shift_pkg::*;

  localparam int DW    = 16;
  localparam int SW    = 4;
  localparam int TAGW  = 4;
  localparam int DEPTH = 2;
`ifdef SHIFT_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  shift_ex_stage_if #(.DW(DW), .SW(SW), .TAGW(TAGW)) bus ();

  shift_ex_stage #(.DW(DW), .SW(SW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int          vis;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                            input logic [3:0] s);
    logic [31:0] dd;
    logic [15:0] fill;
    dd   = {d, d};
    fill = d[15] ? ~(16'hFFFF >> s) : 16'h0000;
    case (op)
      2'b00:   ref_shift = 16'(32'(d) * (32'd1 << s));
      2'b01:   ref_shift = d / (16'd1 << s);
      2'b10:   ref_shift = 16'(dd >> (16 - s));
      default: ref_shift = (d / (16'd1 << s)) | fill;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything accepted and not yet popped, each with its first visible cycle.
  always @(posedge rst) q.delete();

  always @(posedge clk) begin : model
    bit   hv, rdy;
    exp_t e;
    hv  = (q.size() > 0) && (q[0].vis <= cyc);
    rdy = !flush && (q.size() < DEPTH);
    cyc = cyc + 1;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (hv && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy) begin
        e.data = ref_shift(bus.in_op, bus.in_data, bus.in_shamt);
        e.tag  = bus.in_tag;
        e.vis  = cyc + LAT - 1;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    ev = (q.size() > 0) && (q[0].vis <= cyc);
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("in_ready", 32'(bus.in_ready), 32'(!flush && (q.size() < DEPTH)));
    if (ev) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].data));
      chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      chk("out_z", 32'(bus.out_z), 32'(q[0].data == 16'h0000));
    end
  end

  task automatic drive(input logic [1:0] op, input logic [15:0] d, input logic [3:0] sh,
                       input logic [3:0] tg);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_tag   = tg;
  endtask

  task automatic wait_acc(input string name, input int maxc);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < maxc && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk(name, 32'(acc), 32'd1);
  endtask

  task automatic send(input string name, input logic [1:0] op, input logic [15:0] d,
                      input logic [3:0] sh, input logic [3:0] tg);
    drive(op, d, sh, tg);
    wait_acc(name, 8);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [15:0] d, input logic [3:0] tg,
                             input logic z);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 8) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_lat"}, 32'(n), 32'(LAT - 1));
    chk({name, "_data"}, 32'(bus.out_data), 32'(d));
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(tg));
    chk({name, "_z"}, 32'(bus.out_z), 32'(z));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    logic [3:0]  sh;
    logic [3:0]  tg;
    logic [15:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[10] = '{
    '{2'b11, 16'h8000, 4'd15, 4'd5,  16'hFFFF, 1'b0},
    '{2'b01, 16'hF000, 4'd4,  4'd6,  16'h0F00, 1'b0},
    '{2'b00, 16'h8000, 4'd1,  4'd7,  16'h0000, 1'b1},
    '{2'b00, 16'h1234, 4'd0,  4'd8,  16'h1234, 1'b0},
    '{2'b01, 16'h1234, 4'd0,  4'd9,  16'h1234, 1'b0},
    '{2'b10, 16'h1234, 4'd0,  4'd10, 16'h1234, 1'b0},
    '{2'b11, 16'h1234, 4'd0,  4'd11, 16'h1234, 1'b0},
    '{2'b10, 16'h1234, 4'd4,  4'd12, 16'h2341, 1'b0},
    '{2'b11, 16'h7F00, 4'd8,  4'd13, 16'h007F, 1'b0},
    '{2'b10, 16'hF00F, 4'd15, 4'd14, 16'hF807, 1'b0}
  };

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin : stim
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    chk("pin_rol", 32'(ref_shift(OP_ROL, 16'h8001, 4'd1)), 32'h0003);
    chk("pin_sra", 32'(ref_shift(OP_SRA, 16'h8000, 4'd15)), 32'hFFFF);
    chk("pin_srl", 32'(ref_shift(OP_SRL, 16'hF000, 4'd4)), 32'h0F00);
    chk("pin_sll", 32'(ref_shift(OP_SLL, 16'h8000, 4'd1)), 32'h0000);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_z", 32'(bus.out_z), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    send("t1_acc", OP_ROL, 16'h8001, 4'd1, 4'd3);
    expect_head("t1", 16'h0003, 4'd3, 1'b0);

    foreach (vecs[i]) begin
      send("t2_acc", vecs[i].op, vecs[i].d, vecs[i].sh, vecs[i].tg);
      expect_head("t2", vecs[i].res, vecs[i].tg, vecs[i].z);
    end

    bus.out_ready = 1'b0;
    send("t3_a", OP_SLL, 16'h0001, 4'd3, 4'd1);
    send("t3_b", OP_SRL, 16'h0100, 4'd8, 4'd2);
    drive(OP_ROL, 16'h00F0, 4'd12, 4'd4);
    repeat (3) begin
      @(negedge clk);
      chk("t3_rdy_low", 32'(bus.in_ready), 32'd0);
      chk("t3_hold", 32'(bus.out_data), 32'h0008);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_rdy_still_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t3_rdy_back", 32'(bus.in_ready), 32'd1);
    chk("t3_head_b", 32'(bus.out_data), 32'h0001);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    expect_head("t3_c", 16'h000F, 4'd4, 1'b0);

    bus.out_ready = 1'b0;
    send("t4_f0", OP_SLL, 16'h0003, 4'd1, 4'd1);
    send("t4_f1", OP_SRL, 16'h0030, 4'd1, 4'd2);
    for (int i = 0; i < 10; i++) begin
      drive(2'(i), 16'hA5C3 ^ 16'(i * 16'h1111), 4'(i + 1), 4'(i));
      acc = 1'b0;
      for (int c = 0; c < 8 && !acc; c++) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1 bus.out_ready = !bus.out_ready;
      end
      chk("t4_acc", 32'(acc), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t4_drained", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b0;
    send("t5_a", OP_SLL, 16'h00FF, 4'd4, 4'd1);
    send("t5_b", OP_SRA, 16'hF000, 4'd2, 4'd2);
    drive(OP_ROL, 16'h1111, 4'd1, 4'd3);
    @(negedge clk);
    chk("t5_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("t5_rdy_flush", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_flushed", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    send("t5_d", OP_SLL, 16'h0001, 4'd1, 4'd1);
    drive(OP_SRL, 16'h8000, 4'd1, 4'd2);
    flush = 1'b1;
    @(negedge clk);
    chk("t5_rdy_forced", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_not_acc", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send("t5_e", OP_SRA, 16'h8F00, 4'd4, 4'd7);
    expect_head("t5_e", 16'hF8F0, 4'd7, 1'b0);

    bus.out_ready = 1'b0;
    send("t6_a", OP_SLL, 16'h0101, 4'd1, 4'd5);
    send("t6_b", OP_SRL, 16'h0404, 4'd2, 4'd6);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_data", 32'(bus.out_data), 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy", 32'(bus.in_ready), 32'd1);
    chk("t6_valid_after", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send("t6_c", OP_ROL, 16'hF00F, 4'd8, 4'd9);
    expect_head("t6_c", 16'h0FF0, 4'd9, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
